// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display path.
package display_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int DISP_DIGITS = 8;
    localparam int BCD_W       = 4 * DISP_DIGITS;

    // Decimal digits needed for a width-bit unsigned value: ceil(width * log10(2)).
    function automatic int int_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blank flags are enabled with LEADING_ZERO_BLANK_EN.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = DISP_DIGITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     digit_blank
);

    localparam int INT_DIGITS = int_digits(WIDTH);
    // Always keep at least one digit above the displayed ones so overflow has a source.
    localparam int SCR_DIGITS = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS + 1;
    localparam int SCR_W      = 4 * SCR_DIGITS;
    localparam int OUT_W      = 4 * DIGITS;
    localparam int CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [SCR_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_done;
    logic [OUT_W-1:0]   r_bcd;
    logic               r_overflow;

    logic [SCR_W-1:0]   w_adj;
    logic [SCR_W-1:0]   w_scr_next;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_ovf;

    for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    assign w_scr_next   = SCR_W'({w_adj, r_shift[WIDTH-1]});
    assign w_shift_next = r_shift << 1;
    assign w_ovf        = |w_scr_next[SCR_W-1:OUT_W];

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        logic all_zero;
        w_blank_next = '0;
        all_zero     = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero        = all_zero && (w_scr_next[4*i +: 4] == 4'd0);
            w_blank_next[i] = all_zero;
        end
    end

    assign digit_blank = r_blank;
`else
    assign digit_blank = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            r_blank    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_scr_next;
                    r_shift   <= w_shift_next;
                    r_count   <= r_count + CNT_W'(1);
                    if (r_count == LAST_CNT) begin
                        r_bcd      <= w_scr_next[OUT_W-1:0];
                        r_overflow <= w_ovf;
`ifdef LEADING_ZERO_BLANK_EN
                        r_blank    <= w_blank_next;
`endif
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule
